// File: rtl/psx_ddr_bridge_mc_if.sv
// Avalon-MM burst bus between the multi-channel PSX bridge (master) and DDR (slave).
interface psx_ddr_bridge_mc_if #(
    parameter  int MEM_DW     = 64,
    parameter  int ADDR_W     = 17,
    parameter  int LINE_BEATS = 4,
    localparam int LW         = $clog2(LINE_BEATS)
);
    logic [ADDR_W-1:0]   targetAddr;
    logic [LW:0]         burstLength;
    logic                busyMem;
    logic                readEnableMem;
    logic                writeEnableMem;
    logic [MEM_DW-1:0]   writeDataMem;
    logic [MEM_DW/8-1:0] byteEnableMem;
    logic                dataValidMem;
    logic [MEM_DW-1:0]   readDataMem;

    modport master (
        output targetAddr, burstLength, readEnableMem, writeEnableMem, writeDataMem, byteEnableMem,
        input  busyMem, dataValidMem, readDataMem
    );

    modport slave (
        input  targetAddr, burstLength, readEnableMem, writeEnableMem, writeDataMem, byteEnableMem,
        output busyMem, dataValidMem, readDataMem
    );
endinterface

// File: rtl/psx_ddr_bridge_mc.sv
// Multi-channel PSX-to-DDR bridge: per-channel command slots, round-robin
// arbitration, one Avalon-MM burst master shared by all channels.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no burst on the bus; grant the next pending channel
// RD_REQ  | read request asserted until accepted (waitrequest low)
// RD_WAIT | collecting read beats into the line buffer
// WR      | presenting write beats; advance on each accepted beat
module psx_ddr_bridge_mc #(
    parameter  int MEM_DW     = 64,
    parameter  int LINE_BEATS = 4,
    parameter  int ADDR_W     = 17,
    parameter  int NCH        = 2,
    localparam int LINE_W     = MEM_DW * LINE_BEATS,
    localparam int BE_W       = LINE_W / 8,
    localparam int BEAT_BE    = MEM_DW / 8,
    localparam int LW         = $clog2(LINE_BEATS),
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_nRst,
    input  logic [NCH-1:0]        i_command,
    input  logic [NCH-1:0]        i_writeElseRead,
    input  logic [NCH*LW-1:0]     i_lenMinus1,
    input  logic [NCH*ADDR_W-1:0] i_addr,
    input  logic [NCH*BE_W-1:0]   i_byteEnable,
    input  logic [NCH*LINE_W-1:0] i_dataClient,
    output logic [NCH-1:0]        o_busyClient,
    output logic [NCH-1:0]        o_dataValidClient,
    output logic [NCH-1:0]        o_writeDone,
    output logic [LINE_W-1:0]     o_dataClient,
    psx_ddr_bridge_mc_if.master   mem
);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR} state_t;

    localparam logic [LW:0] ONE_BEAT = 1;

    state_t state, stateNext;

    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    slotWr;
    logic [LW-1:0]     slotLen  [NCH];
    logic [ADDR_W-1:0] slotAddr [NCH];
    logic [BE_W-1:0]   slotBe   [NCH];
    logic [LINE_W-1:0] slotData [NCH];

    logic [CW-1:0]     rr;
    logic [CW-1:0]     actCh;
    logic [ADDR_W-1:0] actAddr;
    logic [LW-1:0]     actLen;
    logic [LW-1:0]     bc;

    logic              grantValid;
    logic [CW-1:0]     grantCh;
    logic              grant;
    logic              rdDone;
    logic              wrDone;
    logic [LW:0]       burstLen;

    assign o_busyClient = pending;
    assign grant        = (state == IDLE) && grantValid;
    assign rdDone       = (state == RD_WAIT) && mem.dataValidMem && (bc == actLen);
    assign wrDone       = (state == WR) && !mem.busyMem && (bc == actLen);
    assign burstLen     = {1'b0, actLen} + ONE_BEAT;

    // Round-robin search: first pending channel starting after the last winner.
    always_comb begin
        grantValid = 1'b0;
        grantCh    = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!grantValid && pending[(int'(rr) + i) % NCH]) begin
                grantValid = 1'b1;
                grantCh    = CW'((int'(rr) + i) % NCH);
            end
        end
    end

    // Pending flags: set on an accepted command, cleared when that channel's burst completes.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            pending <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (!pending[c] && i_command[c]) begin
                    pending[c] <= 1'b1;
                end else if ((rdDone || wrDone) && (actCh == CW'(c))) begin
                    pending[c] <= 1'b0;
                end
            end
        end
    end

    // Slot payload; only written while the slot is free, so it is stable for the whole burst.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!pending[c] && i_command[c]) begin
                slotWr[c]   <= i_writeElseRead[c];
                slotLen[c]  <= i_lenMinus1[c*LW +: LW];
                slotAddr[c] <= i_addr[c*ADDR_W +: ADDR_W];
                slotBe[c]   <= i_byteEnable[c*BE_W +: BE_W];
                slotData[c] <= i_dataClient[c*LINE_W +: LINE_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state and bus outputs; the bus reads all zero while idle.
    always_comb begin
        stateNext          = state;
        mem.readEnableMem  = 1'b0;
        mem.writeEnableMem = 1'b0;
        mem.targetAddr     = '0;
        mem.burstLength    = '0;
        mem.writeDataMem   = '0;
        mem.byteEnableMem  = '0;
        case (state)
            IDLE: begin
                if (grantValid) begin
                    stateNext = slotWr[grantCh] ? WR : RD_REQ;
                end
            end
            RD_REQ: begin
                mem.readEnableMem = 1'b1;
                mem.targetAddr    = actAddr;
                mem.burstLength   = burstLen;
                mem.byteEnableMem = '1;
                if (!mem.busyMem) begin
                    stateNext = RD_WAIT;
                end
            end
            RD_WAIT: begin
                mem.targetAddr    = actAddr;
                mem.burstLength   = burstLen;
                mem.byteEnableMem = '1;
                if (rdDone) begin
                    stateNext = IDLE;
                end
            end
            WR: begin
                mem.writeEnableMem = 1'b1;
                mem.targetAddr     = actAddr;
                mem.burstLength    = burstLen;
                mem.writeDataMem   = slotData[actCh][int'(bc)*MEM_DW +: MEM_DW];
                mem.byteEnableMem  = slotBe[actCh][int'(bc)*BEAT_BE +: BEAT_BE];
                if (wrDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Active burst registers, beat counter, read line assembly and completion pulses.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            rr                <= CW'(NCH - 1);
            actCh             <= '0;
            actAddr           <= '0;
            actLen            <= '0;
            bc                <= '0;
            o_dataClient      <= '0;
            o_dataValidClient <= '0;
            o_writeDone       <= '0;
        end else begin
            o_dataValidClient <= '0;
            o_writeDone       <= '0;
            if (grant) begin
                rr      <= grantCh;
                actCh   <= grantCh;
                actAddr <= slotAddr[grantCh];
                actLen  <= slotLen[grantCh];
                bc      <= '0;
                // Beats beyond a short burst's length must read back as zero.
                if (!slotWr[grantCh]) begin
                    o_dataClient <= '0;
                end
            end
            if ((state == RD_WAIT) && mem.dataValidMem) begin
                o_dataClient[int'(bc)*MEM_DW +: MEM_DW] <= mem.readDataMem;
                bc <= bc + LW'(1);
            end
            if ((state == WR) && !mem.busyMem) begin
                bc <= bc + LW'(1);
            end
            if (rdDone) begin
                o_dataValidClient[actCh] <= 1'b1;
            end
            if (wrDone) begin
                o_writeDone[actCh] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psx_ddr_bridge_mc.sv
// Directed bench for the two-channel bridge: round-robin, short read,
// strobe-while-busy, masked write under waitrequest, reset mid-burst.
module tb_psx_ddr_bridge_mc;
    localparam int MEM_DW = 64;
    localparam int LINE_BEATS = 4;
    localparam int ADDR_W = 17;
    localparam int NCH = 2;
    localparam int LW = 2;
    localparam int LINE_W = 256;
    localparam int BE_W = 32;

    logic                  i_clk = 1'b0;
    logic                  i_nRst = 1'b0;
    logic [NCH-1:0]        i_command = '0;
    logic [NCH-1:0]        i_writeElseRead = '0;
    logic [NCH*LW-1:0]     i_lenMinus1 = '0;
    logic [NCH*ADDR_W-1:0] i_addr = '0;
    logic [NCH*BE_W-1:0]   i_byteEnable = '0;
    logic [NCH*LINE_W-1:0] i_dataClient = '0;
    logic [NCH-1:0]        o_busyClient;
    logic [NCH-1:0]        o_dataValidClient;
    logic [NCH-1:0]        o_writeDone;
    logic [LINE_W-1:0]     o_dataClient;

    psx_ddr_bridge_mc_if #(.MEM_DW(MEM_DW), .ADDR_W(ADDR_W), .LINE_BEATS(LINE_BEATS)) mem ();

    psx_ddr_bridge_mc #(.MEM_DW(MEM_DW), .LINE_BEATS(LINE_BEATS), .ADDR_W(ADDR_W), .NCH(NCH)) dut (
        .i_clk(i_clk), .i_nRst(i_nRst), .i_command(i_command), .i_writeElseRead(i_writeElseRead),
        .i_lenMinus1(i_lenMinus1), .i_addr(i_addr), .i_byteEnable(i_byteEnable),
        .i_dataClient(i_dataClient), .o_busyClient(o_busyClient),
        .o_dataValidClient(o_dataValidClient), .o_writeDone(o_writeDone),
        .o_dataClient(o_dataClient), .mem(mem)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Bus monitor, sampling 2 time units after each falling edge.
    int          rdCycles = 0;
    int          dvcCount = 0;
    logic [7:0]  beQ[$];
    logic [63:0] wdQ[$];
    logic [16:0] startQ[$];
    bit          prevActive = 1'b0;
    always begin
        @(negedge i_clk);
        #2;
        if (mem.readEnableMem) rdCycles++;
        if (mem.writeEnableMem && !mem.busyMem) begin
            beQ.push_back(mem.byteEnableMem);
            wdQ.push_back(mem.writeDataMem);
        end
        if ((mem.readEnableMem || mem.writeEnableMem) && !prevActive) startQ.push_back(mem.targetAddr);
        prevActive = mem.readEnableMem || mem.writeEnableMem;
        if (o_dataValidClient != '0) dvcCount++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setCmd(input int ch, input bit wr, input logic [1:0] len, input logic [16:0] addr,
                          input logic [31:0] be, input logic [255:0] data);
        i_writeElseRead[ch]       = wr;
        i_lenMinus1[ch*LW +: LW]  = len;
        i_addr[ch*ADDR_W +: ADDR_W] = addr;
        i_byteEnable[ch*BE_W +: BE_W] = be;
        i_dataClient[ch*LINE_W +: LINE_W] = data;
    endtask

    // Returns at a falling edge where the read request is visible (accepted at the next edge).
    task automatic waitReadReq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem.readEnableMem) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic waitWrite(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem.writeEnableMem) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    // Called right after waitReadReq: one idle cycle after acceptance, then n back-to-back beats.
    task automatic driveBeats(input int n, input logic [63:0] base);
        @(negedge i_clk);
        @(negedge i_clk);
        for (int k = 0; k < n; k++) begin
            mem.dataValidMem = 1'b1;
            mem.readDataMem  = base + 64'(k);
            @(negedge i_clk);
        end
        mem.dataValidMem = 1'b0;
        mem.readDataMem  = '0;
    endtask

    initial begin
        bit ok;
        int s0, r0, w0, d0;
        logic [63:0] a0, a1, a2, a3, b0, b1, c0, d[4];

        mem.busyMem = 1'b0;
        mem.dataValidMem = 1'b0;
        mem.readDataMem = '0;
        a0 = 64'hA0A0_0000_0000_0000; a1 = a0 + 1; a2 = a0 + 2; a3 = a0 + 3;
        b0 = 64'hB0B0_0000_0000_0000; b1 = b0 + 1;
        c0 = 64'hC0C0_0000_0000_0000;
        for (int k = 0; k < 4; k++) d[k] = 64'hD0D0_0000_0000_0000 + 64'(k);

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst_busy", o_busyClient, 0);
        chk("rst_rd", mem.readEnableMem, 0);
        chk("rst_wr", mem.writeEnableMem, 0);
        chk("rst_addr", mem.targetAddr, 0);
        chk("rst_len", mem.burstLength, 0);
        chk("rst_line", o_dataClient, 0);
        chk("rst_be", mem.byteEnableMem, 0);

        // Simultaneous strobes at reset release, ch0 re-strobes on completion: order 0,1,0
        s0 = startQ.size();
        i_nRst = 1'b1;
        setCmd(0, 1'b0, 2'd1, 17'h00200, 32'h0, 256'h0);
        setCmd(1, 1'b1, 2'd0, 17'h00300, 32'h0000_00FF, 256'h1234_5678);
        i_command = 2'b11;
        @(negedge i_clk);
        i_command = 2'b00;
        chk("rr_busy_both", o_busyClient, 2'b11);
        waitReadReq(ok);
        chk("rr_rd0_seen", ok, 1);
        chk("rr_rd0_addr", mem.targetAddr, 17'h00200);
        chk("rr_rd0_len", mem.burstLength, 2);
        driveBeats(2, b0);
        chk("rr_rd0_dvc", o_dataValidClient, 2'b01);
        chk("rr_rd0_line", o_dataClient, {128'h0, b1, b0});
        setCmd(0, 1'b0, 2'd0, 17'h00400, 32'h0, 256'h0);
        i_command = 2'b01;
        @(negedge i_clk);
        i_command = 2'b00;
        waitReadReq(ok);
        chk("short_seen", ok, 1);
        chk("short_addr", mem.targetAddr, 17'h00400);
        chk("short_len", mem.burstLength, 1);
        driveBeats(1, c0);
        chk("short_dvc", o_dataValidClient, 2'b01);
        chk("short_upper_zero", o_dataClient[255:64], 0);
        chk("short_beat0", o_dataClient[63:0], c0);
        chk("rr_nbursts", startQ.size() - s0, 3);
        if (startQ.size() >= s0 + 3) begin
            chk("rr_grant1", startQ[s0], 17'h00200);
            chk("rr_grant2", startQ[s0+1], 17'h00300);
            chk("rr_grant3", startQ[s0+2], 17'h00400);
        end

        // Single read, no waits, plus an ignored strobe while busy
        s0 = startQ.size(); r0 = rdCycles; w0 = wdQ.size();
        @(negedge i_clk);
        setCmd(0, 1'b0, 2'd3, 17'h00100, 32'h0, 256'h0);
        i_command = 2'b01;
        @(negedge i_clk);
        chk("rd_busy", o_busyClient, 2'b01);
        setCmd(0, 1'b1, 2'd3, 17'h1FFFF, 32'hFFFF_FFFF, {4{64'hDEAD_BEEF}});
        i_command = 2'b01;
        @(negedge i_clk);
        i_command = 2'b00;
        waitReadReq(ok);
        chk("rd_seen", ok, 1);
        chk("rd_addr", mem.targetAddr, 17'h00100);
        chk("rd_len", mem.burstLength, 4);
        chk("rd_be_ones", mem.byteEnableMem, 8'hFF);
        driveBeats(4, a0);
        chk("rd_dvc", o_dataValidClient, 2'b01);
        chk("rd_line", o_dataClient, {a3, a2, a1, a0});
        chk("rd_busy_drop", o_busyClient, 2'b00);
        repeat (6) @(negedge i_clk);
        chk("rd_strobes", rdCycles - r0, 1);
        chk("busy_ignored_bursts", startQ.size() - s0, 1);
        chk("busy_ignored_nowrite", wdQ.size() - w0, 0);
        chk("busy_ignored_idle", o_busyClient, 2'b00);

        // Masked write on ch1, waitrequest on the 2nd beat for 3 cycles
        w0 = wdQ.size();
        setCmd(1, 1'b1, 2'd3, 17'h00ABC, 32'h00FF_F00F, {d[3], d[2], d[1], d[0]});
        i_command = 2'b10;
        @(negedge i_clk);
        i_command = 2'b00;
        waitWrite(ok);
        chk("wr_seen", ok, 1);
        chk("wr_addr", mem.targetAddr, 17'h00ABC);
        chk("wr_len", mem.burstLength, 4);
        chk("wr_beat0", mem.writeDataMem, d[0]);
        @(negedge i_clk);
        mem.busyMem = 1'b1;
        chk("wr_beat1", mem.writeDataMem, d[1]);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("wr_hold_data", mem.writeDataMem, d[1]);
            chk("wr_hold_be", mem.byteEnableMem, 8'hF0);
            chk("wr_hold_addr", mem.targetAddr, 17'h00ABC);
            chk("wr_hold_len", mem.burstLength, 4);
        end
        mem.busyMem = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_writeDone != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wr_done_seen", ok, 1);
        chk("wr_done", o_writeDone, 2'b10);
        chk("wr_busy_drop", o_busyClient, 2'b00);
        chk("wr_nbeats", wdQ.size() - w0, 4);
        if (wdQ.size() >= w0 + 4) begin
            chk("wr_be0", beQ[w0], 8'h0F);
            chk("wr_be1", beQ[w0+1], 8'hF0);
            chk("wr_be2", beQ[w0+2], 8'hFF);
            chk("wr_be3", beQ[w0+3], 8'h00);
            chk("wr_d0", wdQ[w0], d[0]);
            chk("wr_d1", wdQ[w0+1], d[1]);
            chk("wr_d2", wdQ[w0+2], d[2]);
            chk("wr_d3", wdQ[w0+3], d[3]);
        end

        // Reset during RD_WAIT, then late beats must not complete anything
        @(negedge i_clk);
        setCmd(0, 1'b0, 2'd3, 17'h00500, 32'h0, 256'h0);
        i_command = 2'b01;
        @(negedge i_clk);
        i_command = 2'b00;
        waitReadReq(ok);
        chk("rst_mid_seen", ok, 1);
        @(negedge i_clk);
        @(negedge i_clk);
        mem.dataValidMem = 1'b1;
        mem.readDataMem = a0;
        @(negedge i_clk);
        mem.dataValidMem = 1'b0;
        i_nRst = 1'b0;
        #1;
        chk("mid_busy", o_busyClient, 0);
        chk("mid_dvc", o_dataValidClient, 0);
        chk("mid_wd", o_writeDone, 0);
        chk("mid_line", o_dataClient, 0);
        chk("mid_rd", mem.readEnableMem, 0);
        chk("mid_wr", mem.writeEnableMem, 0);
        chk("mid_addr", mem.targetAddr, 0);
        chk("mid_len", mem.burstLength, 0);
        chk("mid_be", mem.byteEnableMem, 0);
        chk("mid_wdata", mem.writeDataMem, 0);
        @(negedge i_clk);
        i_nRst = 1'b1;
        d0 = dvcCount; r0 = rdCycles;
        for (int k = 1; k < 4; k++) begin
            mem.dataValidMem = 1'b1;
            mem.readDataMem = a0 + 64'(k);
            @(negedge i_clk);
        end
        mem.dataValidMem = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("late_no_dvc", dvcCount - d0, 0);
        chk("late_no_req", rdCycles - r0, 0);
        chk("late_busy", o_busyClient, 0);
        chk("late_line", o_dataClient, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psx_ddr_bridge_mc.md
# psx_ddr_bridge_mc

Parametrised multi-channel successor to the single-client PSX-to-DDR bridge. It accepts line-sized read and write commands from NCH independent GPU-side clients and latches each into a per-channel pending slot. A round-robin arbiter serialises the pending commands onto one Avalon-MM burst master. Burst length and byte enables are supplied per command, and read data is returned as a full line to the owning channel.

## Interface
- MEM_DW, 64: Avalon data width in bits, multiple of 16.
- LINE_BEATS, 4: beats per client line, power of 2, ≥2. LINE_W = MEM_DW*LINE_BEATS; BE_W = LINE_W/8; LW = $clog2(LINE_BEATS).
- ADDR_W, 17: Avalon word (beat) address width.
- NCH, 2: client channel count, 1..8.
- i_clk  in  1  clock
- i_nRst  in  1  asynchronous active-low reset
- i_command  in  NCH  per-channel single-cycle command strobe
- i_writeElseRead  in  NCH  1 = write, 0 = read
- i_lenMinus1  in  NCH*LW  beats-1 per channel
- i_addr  in  NCH*ADDR_W  beat start address per channel
- i_byteEnable  in  NCH*BE_W  write byte enables; beat k uses bits [k*MEM_DW/8 +: MEM_DW/8]
- i_dataClient  in  NCH*LINE_W  write line per channel; beat k = bits [k*MEM_DW +: MEM_DW]
- o_busyClient  out  NCH  channel slot occupied
- o_dataValidClient  out  NCH  one-cycle read-complete pulse
- o_writeDone  out  NCH  one-cycle write-complete pulse
- o_dataClient  out  LINE_W  read line, shared by all channels, qualified by o_dataValidClient
- o_targetAddr  out  ADDR_W  burst start address
- o_burstLength  out  LW+1  burst beat count
- i_busyMem  in  1  Avalon waitrequest
- o_readEnableMem  out  1  Avalon read
- o_writeEnableMem  out  1  Avalon write
- o_dataMem  out  MEM_DW  write beat data
- o_byteEnableMem  out  MEM_DW/8  write beat enables; all ones during read
- i_dataValidMem  in  1  Avalon readdatavalid
- i_dataMem  in  MEM_DW  read beat data

## Operation
- **Capture.** When i_command[c] is high and o_busyClient[c] is low, the slot for channel c latches all command fields and the data line, and pending[c] is set. o_busyClient[c] equals pending[c]. A command that arrives while busy is ignored and the slot is left unchanged.
- **Arbitration.** Arbitration happens only in IDLE. The winner is the first pending channel found searching from rr+1 modulo NCH. On grant, rr is set to the winner, the channel, address, length and direction are copied into the active registers, and the beat counter bc is cleared. On a read grant, o_dataClient is cleared to zero.
- **States.**
  - IDLE: any pending channel triggers a grant; go to RD_REQ or WR.
  - RD_REQ: o_readEnableMem=1 until a cycle with i_busyMem=0, then go to RD_WAIT.
  - RD_WAIT: each i_dataValidMem writes i_dataMem to beat bc of o_dataClient, then bc++. When the last beat (bc==len) arrives, go to IDLE.
  - WR: o_writeEnableMem=1. o_dataMem and o_byteEnableMem are taken from beat bc of the active slot. Each cycle with i_busyMem=0 advances bc. When the last beat is accepted, go to IDLE.
- **Bus fields.** o_targetAddr = active address, and o_burstLength = len+1. Both are held constant for the whole burst, including all write beats. Both read 0 in IDLE.
- **Completion.**
  - On the edge after the last read beat, pending[c] clears and o_dataValidClient[c] pulses for one cycle.
  - On the edge after the last accepted write beat, pending[c] clears and o_writeDone[c] pulses.
- **Unmasked beats.** Read beats beyond len stay zero.
- **Ignored input.** i_dataValidMem outside RD_WAIT is ignored.
- **Reset.** All outputs are 0 and all pending bits are cleared. rr is set to NCH-1, so channel 0 wins first. The state machine returns to IDLE immediately, and any burst in flight is abandoned.

## Timing
- **Write, command at cycle T.**
  - T+1: pending set, o_busyClient high.
  - T+1 edge: grant.
  - T+2: first beat on the bus.
  - With no waitrequest, beats occupy T+2..T+2+len.
  - The done pulse and busy drop occur at T+3+len.
- **Read.** o_readEnableMem is high from T+2. o_dataValidClient[c] is high the cycle after the last i_dataValidMem, with o_dataClient complete in that same cycle.
- **Back-to-back.** A channel may issue its next command in the cycle its busy is low. That is the same cycle as its pulse.
- **Bus gap.** At least one IDLE cycle separates consecutive bursts.
- **Simultaneous strobes.** Commands from several channels in the same cycle are all captured. They are then served in round-robin order.

## Test plan
- **Single read, no waits.** Stimulus: NCH=2, ch0 read with addr=0x00100 and len=3; memory returns beats A0..A3, one per cycle, 2 cycles after request acceptance. Required: exactly one read strobe with o_targetAddr=0x00100 and o_burstLength=4; then o_dataValidClient=01 with o_dataClient={A3,A2,A1,A0}; then busy drops.
- **Masked write under waitrequest.** Stimulus: ch1 write with len=3 and byteEnable[31:0]=0x00FF_F00F; i_busyMem high on the 2nd beat for 3 cycles. Required: beat 1 is held stable for 3 cycles; the beat enables per beat are 0x0F, 0xF0, 0xFF, 0x00; exactly 4 accepted beats; then o_writeDone=10.
- **Simultaneous strobes and round-robin.** Stimulus: ch0 and ch1 both strobe at reset release; then ch0 re-strobes immediately after completing. Required: the grant order is 0, 1, 0.
- **Short read.** Stimulus: ch0 read with len=0. Required: o_burstLength=1, and o_dataClient[255:64]=0.
- **Strobe while busy.** Stimulus: ch0 strobes again while busy, with addr=0x1FFFF. Required: it is ignored; no burst is issued to 0x1FFFF.
- **Reset mid-burst.** Stimulus: assert i_nRst during RD_WAIT. Required: all outputs are 0 immediately; after release, late i_dataValidMem beats produce no o_dataValidClient pulse.
